// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and C2/A2/D2 line-bus sequencer.
// Grants one whole-line request at a time, drives the command and write beats,
// waits for the memory response with a timeout, and deserialises read lines.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned BEATS   = 8,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned LINE_W = DATA_W * BEATS
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              REQ0_VALID,
  input  logic              REQ0_WR,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [LINE_W-1:0] REQ0_WLINE,
  input  logic              REQ1_VALID,
  input  logic              REQ1_WR,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [LINE_W-1:0] REQ1_WLINE,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic              ERR,
  output logic [LINE_W-1:0] RLINE,
  output logic [1:0]        C2_OUT,
  output logic              C2_OE,
  output logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] D2_OUT,
  output logic              D2_OE,
  input  logic [1:0]        C2_IN,
  input  logic [DATA_W-1:0] D2_IN
);

  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;
  localparam logic [1:0] RSP_OK    = 2'd1;

  typedef enum logic [2:0] {StIdle, StCmd, StWait, StRbeat, StFin} state_t;

  state_t              r_state;
  logic                r_granted;  // grant pulse issued, CMD starts next cycle
  logic                r_last;     // port granted most recently
  logic                r_port;     // port owning the current transaction
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wline;
  logic [LINE_W-1:0]   r_buf;      // read beats collected so far
  logic [BEAT_W-1:0]   r_beat;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_done0;
  logic                r_done1;
  logic                r_err;
  logic [LINE_W-1:0]   r_rline;
  logic [1:0]          r_c2_out;
  logic                r_c2_oe;
  logic [ADDR_W-1:0]   r_a2;
  logic [DATA_W-1:0]   r_d2_out;
  logic                r_d2_oe;

  logic                w_pick1;
  logic [BEAT_W-1:0]   w_next_beat;
  logic [DATA_W-1:0]   w_wbeat;
  logic [LINE_W-1:0]   w_rline_next;

  // Port 1 wins when alone, or on a tie when port 0 was granted last.
  assign w_pick1 = REQ1_VALID & (~REQ0_VALID | ~r_last);
  assign w_next_beat = r_beat + BEAT_W'(1);

  // Next write beat and the read buffer with the current D2_IN beat merged in.
  always_comb begin
    w_wbeat = r_wline[int'(w_next_beat) * DATA_W +: DATA_W];
    w_rline_next = r_buf;
    w_rline_next[int'(r_beat) * DATA_W +: DATA_W] = D2_IN;
  end

  // Sequencer FSM with registered bus and handshake outputs.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= StIdle;
      r_granted <= 1'b0;
      r_last    <= 1'b1;
      r_port    <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wline   <= '0;
      r_buf     <= '0;
      r_beat    <= '0;
      r_cnt     <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_err     <= 1'b0;
      r_rline   <= '0;
      r_c2_out  <= CMD_NOP;
      r_c2_oe   <= 1'b0;
      r_a2      <= '0;
      r_d2_out  <= '0;
      r_d2_oe   <= 1'b0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_err <= 1'b0;
          if (r_granted) begin
            r_granted <= 1'b0;
            r_state   <= StCmd;
            r_beat    <= '0;
            r_c2_oe   <= 1'b1;
            r_c2_out  <= r_wr ? CMD_WRITE : CMD_READ;
            r_a2      <= r_addr;
            r_d2_oe   <= r_wr;
            r_d2_out  <= r_wr ? r_wline[DATA_W-1:0] : '0;
          end else if (REQ0_VALID || REQ1_VALID) begin
            r_granted <= 1'b1;
            r_port    <= w_pick1;
            r_last    <= w_pick1;
            r_gnt0    <= ~w_pick1;
            r_gnt1    <= w_pick1;
            r_wr      <= w_pick1 ? REQ1_WR    : REQ0_WR;
            r_addr    <= w_pick1 ? REQ1_ADDR  : REQ0_ADDR;
            r_wline   <= w_pick1 ? REQ1_WLINE : REQ0_WLINE;
          end
        end
        StCmd: begin
          if (r_wr && (r_beat != LAST_BEAT)) begin
            r_beat   <= w_next_beat;
            r_d2_out <= w_wbeat;
          end else begin
            r_state  <= StWait;
            r_beat   <= '0;
            r_cnt    <= '0;
            r_c2_oe  <= 1'b0;
            r_c2_out <= CMD_NOP;
            r_a2     <= '0;
            r_d2_oe  <= 1'b0;
            r_d2_out <= '0;
          end
        end
        StWait: begin
          if (C2_IN == RSP_OK) begin
            if (r_wr) begin
              r_state <= StFin;
              r_done0 <= ~r_port;
              r_done1 <= r_port;
            end else if (r_beat == LAST_BEAT) begin
              // Single-beat lines complete on the response itself.
              r_state <= StFin;
              r_rline <= w_rline_next;
              r_done0 <= ~r_port;
              r_done1 <= r_port;
            end else begin
              r_state <= StRbeat;
              r_buf   <= w_rline_next;
              r_beat  <= w_next_beat;
            end
          end else if (r_cnt == CNT_MAX) begin
            r_state <= StFin;
            r_err   <= 1'b1;
            r_done0 <= ~r_port;
            r_done1 <= r_port;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StRbeat: begin
          if (r_beat == LAST_BEAT) begin
            r_state <= StFin;
            r_rline <= w_rline_next;
            r_done0 <= ~r_port;
            r_done1 <= r_port;
          end else begin
            r_buf  <= w_rline_next;
            r_beat <= w_next_beat;
          end
        end
        StFin: begin
          r_state <= StIdle;
          r_err   <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign GNT0   = r_gnt0;
  assign GNT1   = r_gnt1;
  assign DONE0  = r_done0;
  assign DONE1  = r_done1;
  assign ERR    = r_err;
  assign RLINE  = r_rline;
  assign C2_OUT = r_c2_out;
  assign C2_OE  = r_c2_oe;
  assign A2     = r_a2;
  assign D2_OUT = r_d2_out;
  assign D2_OE  = r_d2_oe;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer for the cache-to-memory line bus (C2/A2/D2). Two line-cache requesters, port 0 and port 1, present whole-line read or write requests. The block grants them round-robin, runs the multi-beat C2 command and data sequence toward the memory controller, and deserialises read lines. It sits between the cache level and the memory controller, and is the only driver of the memory side of the bus.

## Interface
Parameters:
- ADDR_W, 15, line address width (no byte offset).
- DATA_W, 16, bus beat width.
- BEATS, 8, beats per line; line width LINE_W = DATA_W*BEATS = 128 bits (16-byte line).
- TIMEOUT, 255, maximum WAIT cycles before aborting; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ0_VALID / REQ1_VALID  in  1  request pending; held until the matching GNT.
- REQ0_WR / REQ1_WR  in  1  1 = WRITE_LINE, 0 = READ_LINE.
- REQ0_ADDR / REQ1_ADDR  in  ADDR_W  line address.
- REQ0_WLINE / REQ1_WLINE  in  LINE_W  write line; sampled only in the GNT cycle.
- GNT0 / GNT1  out  1  one-cycle pulse: request accepted.
- DONE0 / DONE1  out  1  one-cycle pulse: transaction finished.
- ERR  out  1  valid with DONE: 1 = timeout.
- RLINE  out  LINE_W  read line; valid with DONE on a read with ERR=0.
- C2_OUT  out  2  command to memory: 0 NOP, 2 READ_LINE, 3 WRITE_LINE.
- C2_OE  out  1  block drives C2 and A2.
- A2  out  ADDR_W  line address to memory.
- D2_OUT  out  DATA_W  write beat.
- D2_OE  out  1  block drives D2.
- C2_IN  in  2  memory response; 1 = RESPONSE.
- D2_IN  in  DATA_W  read beat.

## Operation
- States: IDLE, CMD, WAIT, RBEAT, FIN.
- IDLE:
  - If any VALID is high, pick a winner, pulse its GNT, latch WR, ADDR and WLINE, then go to CMD.
  - With a single requester valid, that requester wins.
  - With both valid, the winner is the port not granted last. A 1-bit last pointer resets to 1, so port 0 wins the first tie.
- CMD (write): BEATS cycles.
  - C2_OE=1, C2_OUT=3, A2 = latched address, D2_OE=1.
  - Beat k drives D2_OUT = WLINE[16k+15:16k], starting at k=0 in the first CMD cycle.
  - Then go to WAIT.
- CMD (read): one cycle with C2_OE=1, C2_OUT=2, A2 = address, D2_OE=0. Then go to WAIT.
- WAIT:
  - All OE signals are 0; C2_OUT=0.
  - Counter increments each cycle. C2_IN is ignored in every state except WAIT and RBEAT.
  - C2_IN==1 on a write: go to FIN.
  - C2_IN==1 on a read: capture D2_IN into beat 0, go to RBEAT.
  - Counter reaching TIMEOUT with no response: set the error flag, go to FIN.
- RBEAT: capture D2_IN into beats 1..BEATS-1 on consecutive cycles, whatever C2_IN is. Then go to FIN.
- FIN: one cycle.
  - DONEn pulses for the latched port, ERR = error flag, RLINE is updated.
  - On a timed-out read, RLINE keeps its previous value.
  - Next state is IDLE. A new grant is possible no earlier than the cycle after FIN.
- Only one transaction is outstanding at a time. A VALID on the losing port stays pending.
- A requester dropping VALID before GNT withdraws its request, with no side effect.
- Asynchronous reset clears state to IDLE, outputs to 0, last pointer to 1 and RLINE to 0. Reset mid-transaction releases the bus immediately and produces no DONE.

## Timing
- Reset values: GNT*, DONE*, ERR, C2_OUT, C2_OE, D2_OE, A2, D2_OUT, RLINE are all 0. All outputs are registered.
- Grant: GNT pulses in cycle t, the first IDLE cycle with VALID high. The first CMD cycle is t+1.
- Write: CMD occupies t+1..t+BEATS. WAIT starts at t+BEATS+1. Response in cycle r gives DONE at r+1.
- Read: CMD at t+1, WAIT from t+2. Response beat 0 in cycle r, beats 1..7 in r+1..r+7, DONE with RLINE at r+BEATS.
- Fastest write: t to DONE = 10 cycles, with the response in the first WAIT cycle.
- Timeout: the first WAIT cycle counts 1. DONE with ERR=1 occurs TIMEOUT+1 cycles after WAIT entry.
- GNT and DONE are never high in the same cycle.

## Test plan
- Read port 0, ADDR=0x1234, memory responds 3 cycles into WAIT with beats 0x0001..0x0008. Required: C2_OUT=2 for one cycle, DONE0 with ERR=0, RLINE=0x0008_0007_..._0001.
- Write port 1, ADDR=0x7FFF, WLINE=0xFEDC..3210. Required: 8 CMD cycles with C2_OUT=3, D2_OUT=0x3210 first and 0xFEDC last. Response gives DONE1 one cycle later.
- Both VALID high from reset, each re-requesting immediately after its DONE. Required: grants alternate 0,1,0,1.
- Memory never responds, TIMEOUT=4. Required: DONE0 with ERR=1 five cycles after WAIT entry, RLINE unchanged, then IDLE.
- RESET_N asserted in the 4th write beat. Required: C2_OE=0 and D2_OE=0 asynchronously, no DONE. After release, the next request is granted normally.
- Spurious C2_IN=1 during write CMD beats. Required: ignored, and the transaction still waits for a response in WAIT.
